// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam int              BCD_DIGIT_W = 4;
  localparam logic [3:0]      BCD_BLANK   = 4'hF;
  localparam logic [3:0]      ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bin_to_bcd_seq_add3_cell.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3_cell
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= ADD3_THRESH) ? din + BCD_DIGIT_W'(3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking of the result is enabled by `define BCD_BLANK_LZ_EN.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int IN_W   = 6,
  parameter int DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_bin,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          ovf
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  state_t            state, state_d;
  logic              in_ready_r;
  logic [IN_W-1:0]   shreg;
  logic [ACC_W-1:0]  acc, acc_adj, acc_shift, bcd_fmt, bcd_r;
  logic [CNT_W-1:0]  cnt;
  logic              ovf_r, ovf_shift;
  logic              accept, last_bit;

  assign accept   = (state == IDLE) && in_valid && in_ready_r;
  assign last_bit = (state == CONV) && (cnt == CNT_W'(1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_cell u_cell (
      .din  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The bit carried out of the top digit means the value no longer fits.
  assign acc_shift = {acc_adj[ACC_W-2:0], shreg[IN_W-1]};
  assign ovf_shift = ovf_r | acc_adj[ACC_W-1];

`ifdef BCD_BLANK_LZ_EN
  logic lead;
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    bcd_fmt = acc_shift;
    lead    = !ovf_shift;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && (acc_shift[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0)) begin
        bcd_fmt[k*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign bcd_fmt = acc_shift;
`endif

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept)    state_d = CONV;
      CONV:    if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge here, so it sits inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready_r <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
      state      <= state_d;
      in_ready_r <= (state_d == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
      ovf_r <= 1'b0;
      bcd_r <= '0;
    end else if (accept) begin
      shreg <= in_bin;
      acc   <= '0;
      cnt   <= CNT_W'(IN_W);
      ovf_r <= 1'b0;
    end else if (state == CONV) begin
      shreg <= shreg << 1;
      acc   <= acc_shift;
      cnt   <= cnt - 1'b1;
      ovf_r <= ovf_shift;
      if (last_bit) bcd_r <= bcd_fmt;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = (state == DONE);
  assign bcd       = bcd_r;
  assign ovf       = ovf_r;

endmodule
